// File: rtl/cdiv_if.sv
// Operand/result handshake bundle for the sequential complex divider.
// Carries the input and output valid/ready pairs and the data beside them.
interface cdiv_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  rea;
    logic signed [7:0]  ima;
    logic signed [7:0]  req;
    logic signed [7:0]  imq;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] rep;
    logic signed [15:0] imp;
    logic               dz;
    logic               ovf;

    modport master (
        output in_valid, rea, ima, req, imq, out_ready,
        input  in_ready, out_valid, rep, imp, dz, ovf
    );

    modport slave (
        input  in_valid, rea, ima, req, imq, out_ready,
        output in_ready, out_valid, rep, imp, dz, ovf
    );
endinterface

// File: rtl/cdiv.sv
// Complex divide a/q = a*conj(q)/|q|^2 via two lockstep restoring dividers, Q(15-FRAC).FRAC out.
// Latency FRAC+18 (FRAC+19 with CDIV_ROUND_EN: one extra bit, round half away from zero); 2 on divide-by-zero.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, never overlapping the output.
module cdiv #(
    parameter int FRAC = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    cdiv_if.slave  bus
);

`ifdef CDIV_ROUND_EN
    localparam int XB = 1;
`else
    localparam int XB = 0;
`endif
    localparam int W  = 16 + FRAC + XB;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;
    state_t state, state_nx;

    logic signed [7:0]  rea_q, ima_q, req_q, imq_q;
    logic               sgn_r, sgn_i;
    logic [15:0]        den;
    logic [W-1:0]       dr_r, dr_i;
    logic [15:0]        rm_r, rm_i;
    logic [CW-1:0]      cnt;
    logic               in_ready_q, out_valid_q, dz_q, ovf_q;
    logic signed [15:0] rep_q, imp_q;
    logic               in_ready_nx, out_valid_nx, last;

    logic signed [16:0] xr, xi, yr, yi, nr_c, ni_c;
    logic signed [15:0] yr16, yi16;
    logic [15:0]        den_c, mr_c, mi_c;
    logic [16:0]        st_r, st_i, fr_c, fi_c;
    logic [W-1:0]       dr_r_nx, dr_i_nx;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rep       = rep_q;
    assign bus.imp       = imp_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;

    // One restoring step: returns {quotient bit, new remainder}; remainder stays below den.
    function automatic logic [16:0] rstep(input logic [15:0] rm, input logic b, input logic [15:0] d);
        logic [16:0] sh;
        sh = {rm, b};
        if (sh >= {1'b0, d})
            return {1'b1, 16'(sh - {1'b0, d})};
        return {1'b0, sh[15:0]};
    endfunction

    // Magnitude (optionally rounded) -> signed, saturated 16-bit; returns {clipped, value}.
    function automatic logic [16:0] fin(input logic neg, input logic [W-1:0] q);
        logic [W-1:0] m;
`ifdef CDIV_ROUND_EN
        m = (q >> 1) + W'(q[0]);
`else
        m = q;
`endif
        if (!neg && m > W'(32767))
            return {1'b1, 16'h7fff};
        if (neg && m > W'(32768))
            return {1'b1, 16'h8000};
        return {1'b0, neg ? 16'(16'd0 - m[15:0]) : m[15:0]};
    endfunction

    always_comb begin
        xr   = 17'(rea_q);
        xi   = 17'(ima_q);
        yr   = 17'(req_q);
        yi   = 17'(imq_q);
        yr16 = 16'(req_q);
        yi16 = 16'(imq_q);
        nr_c = xr * yr + xi * yi;
        ni_c = xi * yr - xr * yi;
        // |q|^2 tops out at 32768, which still fits 16 bits unsigned
        den_c = 16'(yr16 * yr16 + yi16 * yi16);
        mr_c  = nr_c[16] ? 16'(16'd0 - nr_c[15:0]) : nr_c[15:0];
        mi_c  = ni_c[16] ? 16'(16'd0 - ni_c[15:0]) : ni_c[15:0];
    end

    always_comb begin
        st_r    = rstep(rm_r, dr_r[W-1], den);
        st_i    = rstep(rm_i, dr_i[W-1], den);
        dr_r_nx = {dr_r[W-2:0], st_r[16]};
        dr_i_nx = {dr_i[W-2:0], st_i[16]};
        fr_c    = fin(sgn_r, dr_r_nx);
        fi_c    = fin(sgn_i, dr_i_nx);
        last    = (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = PREP;
            PREP:    state_nx = (den_c == 16'd0) ? DONE : DIV;
            DIV:     if (last) state_nx = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready_nx  = (state_nx == IDLE);
        out_valid_nx = (state == DONE) && !(out_valid_q && bus.out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rea_q       <= '0;
            ima_q       <= '0;
            req_q       <= '0;
            imq_q       <= '0;
            sgn_r       <= 1'b0;
            sgn_i       <= 1'b0;
            den         <= '0;
            dr_r        <= '0;
            dr_i        <= '0;
            rm_r        <= '0;
            rm_i        <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rep_q       <= '0;
            imp_q       <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_nx;
            out_valid_q <= out_valid_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    rea_q <= bus.rea;
                    ima_q <= bus.ima;
                    req_q <= bus.req;
                    imq_q <= bus.imq;
                end
                PREP: begin
                    sgn_r <= nr_c[16];
                    sgn_i <= ni_c[16];
                    den   <= den_c;
                    dr_r  <= W'(mr_c) << (W - 16);
                    dr_i  <= W'(mi_c) << (W - 16);
                    rm_r  <= '0;
                    rm_i  <= '0;
                    cnt   <= '0;
                    dz_q  <= (den_c == 16'd0);
                    if (den_c == 16'd0) begin
                        rep_q <= '0;
                        imp_q <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                DIV: begin
                    dr_r <= dr_r_nx;
                    dr_i <= dr_i_nx;
                    rm_r <= st_r[15:0];
                    rm_i <= st_i[15:0];
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        rep_q <= fr_c[15:0];
                        imp_q <= fi_c[15:0];
                        ovf_q <= fr_c[16] | fi_c[16];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdiv.sv
// Directed self-checking bench for cdiv at FRAC = 8, both rounding builds.
module tb_cdiv;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cdiv_if bus();
    cdiv #(.FRAC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef CDIV_ROUND_EN
    localparam int LAT = 27;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 26;
    localparam bit RND = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Waits for idle, presents operands for one accepting edge, returns cycles until out_valid.
    task automatic op(input logic signed [7:0] ar, ai, qr, qi, output int lat);
        int k;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus.rea      = ar;
        bus.ima      = ai;
        bus.req      = qr;
        bus.imq      = qi;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 200);
    endtask

    task automatic op_chk(input string tag, input logic signed [7:0] ar, ai, qr, qi,
                          input int erp, input int eip, input int edz, input int eovf, input int elat);
        int lat;
        op(ar, ai, qr, qi, lat);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".rep"}, bus.rep, erp);
        check({tag, ".imp"}, bus.imp, eip);
        check({tag, ".dz"},  {31'd0, bus.dz}, edz);
        check({tag, ".ovf"}, {31'd0, bus.ovf}, eovf);
    endtask

    initial begin
        int lat;
        int seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.rea = '0;
        bus.ima = '0;
        bus.req = '0;
        bus.imq = '0;

        #1 rst_n = 1'b0;
        #3;
        check("rst.in_ready",  {31'd0, bus.in_ready}, 1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 0);
        check("rst.rep", bus.rep, 0);
        check("rst.imp", bus.imp, 0);
        check("rst.dz",  {31'd0, bus.dz}, 0);
        check("rst.ovf", {31'd0, bus.ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        op_chk("real",   4,    0,    2,  0,   512,     0,      0, 0, LAT);
        op_chk("divj",   1,    0,    0,  2,   0,      -128,    0, 0, LAT);
        op_chk("jdivj",  0,    1,    0,  1,   256,     0,      0, 0, LAT);
        op_chk("third",  2,    0,    3,  0,   RND ? 171 : 170,   0, 0, 0, LAT);
        op_chk("nthird", -2,   0,    3,  0,   RND ? -171 : -170, 0, 0, 0, LAT);
        op_chk("mixed",  3,    4,    1,  2,   563,    -102,    0, 0, LAT);
        op_chk("dz",     5,    -3,   0,  0,   0,       0,      1, 0, 2);
        op_chk("satpos", -128, 0,    -1, 0,   32767,   0,      0, 1, LAT);
        op_chk("negmax", 0,    -128, 1,  0,   0,      -32768,  0, 0, LAT);

        // Hold the result under backpressure.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        op(4, 0, 2, 0, lat);
        check("hold.lat", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold.vld", {31'd0, bus.out_valid}, 1);
            check("hold.rep", bus.rep, 512);
            check("hold.rdy", {31'd0, bus.in_ready}, 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 check("hold.drop", {31'd0, bus.out_valid}, 0);

        // Abort mid-divide with reset.
        @(negedge clk);
        bus.rea = 8'sd3;
        bus.ima = 8'sd4;
        bus.req = 8'sd1;
        bus.imq = 8'sd2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.in_ready",  {31'd0, bus.in_ready}, 1);
        check("abort.out_valid", {31'd0, bus.out_valid}, 0);
        check("abort.rep", bus.rep, 0);
        check("abort.imp", bus.imp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.out_valid === 1'b1) seen = 1;
        end
        check("abort.no_result", seen, 0);
        op_chk("post", 3, 4, 1, 2, 563, -102, 0, 0, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
